// File: rtl/mem_access.sv
// Memory-access stage: drives a req/ack data-memory port with a timeout, formats load results.
// Sub-word loads/stores (lb/lbu/lh/lhu/sb/sh) are built only when MEM_ACCESS_SUBWORD_EN is defined.
module mem_access #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] ALUOutin,
  input  logic [31:0] Bin,
  input  logic [31:0] IRin,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] MEMOutout,
  output logic [31:0] ALUOutout,
  output logic [31:0] IRout,
  output logic        out_valid,
  output logic        misalign,
  output logic        timeout
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
`ifdef MEM_ACCESS_SUBWORD_EN
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
`endif

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      alu_q;
  logic [31:0]      ir_q;

  logic [5:0]  op;
  logic        is_mem;
  logic        is_store;
  logic        mis;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic        accept;

`ifdef MEM_ACCESS_SUBWORD_EN
  function automatic logic [31:0] load_result(input logic [5:0] opc, input logic [1:0] a,
                                              input logic [31:0] rd);
    logic [7:0]  b8;
    logic [15:0] h16;
    b8  = rd[{a, 3'b000} +: 8];
    h16 = a[1] ? rd[31:16] : rd[15:0];
    case (opc)
      OP_LW:   return rd;
      OP_LB:   return {{24{b8[7]}}, b8};
      OP_LBU:  return {24'h0, b8};
      OP_LH:   return {{16{h16[15]}}, h16};
      OP_LHU:  return {16'h0, h16};
      default: return 32'h0;
    endcase
  endfunction
`else
  function automatic logic [31:0] load_result(input logic [5:0] opc, input logic [31:0] rd);
    return (opc == OP_LW) ? rd : 32'h0;
  endfunction
`endif

  assign stall  = (state == REQ);
  assign accept = in_valid && !stall;
  assign op     = IRin[31:26];

  always_comb begin
    is_mem   = 1'b0;
    is_store = 1'b0;
    mis      = 1'b0;
    be_n     = 4'b1111;
    wdata_n  = Bin;
    case (op)
      OP_LW: begin
        is_mem = 1'b1;
        mis    = (ALUOutin[1:0] != 2'b00);
      end
      OP_SW: begin
        is_mem   = 1'b1;
        is_store = 1'b1;
        mis      = (ALUOutin[1:0] != 2'b00);
      end
`ifdef MEM_ACCESS_SUBWORD_EN
      OP_LB, OP_LBU: is_mem = 1'b1;
      OP_LH, OP_LHU: begin
        is_mem = 1'b1;
        mis    = ALUOutin[0];
      end
      OP_SB: begin
        is_mem   = 1'b1;
        is_store = 1'b1;
        be_n     = 4'b0001 << ALUOutin[1:0];
        wdata_n  = {4{Bin[7:0]}};
      end
      OP_SH: begin
        is_mem   = 1'b1;
        is_store = 1'b1;
        mis      = ALUOutin[0];
        be_n     = ALUOutin[1] ? 4'b1100 : 4'b0011;
        wdata_n  = {2{Bin[15:0]}};
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      alu_q      <= '0;
      ir_q       <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_be    <= 4'b0000;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      MEMOutout  <= '0;
      ALUOutout  <= '0;
      IRout      <= '0;
      out_valid  <= 1'b0;
      misalign   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      // Status pulses and IRout default to a bubble; result data holds.
      out_valid <= 1'b0;
      misalign  <= 1'b0;
      timeout   <= 1'b0;
      IRout     <= '0;
      if (state == IDLE) begin
        if (accept) begin
          if (!is_mem) begin
            ALUOutout <= ALUOutin;
            IRout     <= IRin;
            MEMOutout <= '0;
            out_valid <= 1'b1;
          end else if (mis) begin
            ALUOutout <= ALUOutin;
            MEMOutout <= '0;
            out_valid <= 1'b1;
            misalign  <= 1'b1;
          end else begin
            state      <= REQ;
            cnt        <= '0;
            alu_q      <= ALUOutin;
            ir_q       <= IRin;
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_be    <= be_n;
            dmem_addr  <= {ALUOutin[31:2], 2'b00};
            dmem_wdata <= wdata_n;
          end
        end
      end else begin
        // Ack takes priority over the timeout limit in the same cycle.
        if (dmem_ack) begin
          state     <= IDLE;
          dmem_req  <= 1'b0;
          dmem_we   <= 1'b0;
          out_valid <= 1'b1;
          IRout     <= ir_q;
          ALUOutout <= alu_q;
`ifdef MEM_ACCESS_SUBWORD_EN
          MEMOutout <= load_result(ir_q[31:26], alu_q[1:0], dmem_rdata);
`else
          MEMOutout <= load_result(ir_q[31:26], dmem_rdata);
`endif
        end else if (cnt == CNT_LIMIT) begin
          state     <= IDLE;
          dmem_req  <= 1'b0;
          dmem_we   <= 1'b0;
          out_valid <= 1'b1;
          timeout   <= 1'b1;
          MEMOutout <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: vector table of single operations plus
// timeout, ack-at-limit, reset-during-request and stray-ack sequences.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] ALUOutin, Bin, IRin;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [31:0] MEMOutout, ALUOutout, IRout;
  logic        out_valid, misalign, timeout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .ALUOutin(ALUOutin), .Bin(Bin), .IRin(IRin),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .MEMOutout(MEMOutout), .ALUOutout(ALUOutout), .IRout(IRout),
    .out_valid(out_valid), .misalign(misalign), .timeout(timeout)
  );

  localparam int K_NONMEM = 0;
  localparam int K_MIS    = 1;
  localparam int K_MEM    = 2;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] ir, alu, b, rdata;
    int          delay;
    logic [31:0] exp_addr, exp_wdata;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int stalls;
    @(negedge clk);
    in_valid = 1'b1; IRin = v.ir; ALUOutin = v.alu; Bin = v.b;
    @(posedge clk); #1;
    in_valid = 1'b0; IRin = 32'h0; ALUOutin = 32'h0; Bin = 32'h0;
    if (v.kind == K_MEM) begin
      check({v.name, ".req"}, {31'h0, dmem_req}, 32'h1);
      check({v.name, ".addr"}, dmem_addr, v.exp_addr);
      check({v.name, ".we"}, {31'h0, dmem_we}, {31'h0, v.exp_we});
      check({v.name, ".be"}, {28'h0, dmem_be}, {28'h0, v.exp_be});
      if (v.exp_we) check({v.name, ".wdata"}, dmem_wdata, v.exp_wdata);
      stalls = 0;
      for (int k = 1; k <= 40 && stall; k++) begin
        stalls++;
        @(negedge clk);
        if (k == v.delay) begin
          dmem_ack = 1'b1; dmem_rdata = v.rdata;
        end
        @(posedge clk); #1;
        dmem_ack = 1'b0;
      end
      check({v.name, ".stall_cycles"}, stalls, v.delay);
    end
    check({v.name, ".out_valid"}, {31'h0, out_valid}, 32'h1);
    check({v.name, ".misalign"}, {31'h0, misalign}, {31'h0, v.kind == K_MIS});
    check({v.name, ".timeout"}, {31'h0, timeout}, 32'h0);
    check({v.name, ".dmem_req_after"}, {31'h0, dmem_req}, 32'h0);
    check({v.name, ".IRout"}, IRout, (v.kind == K_MIS) ? 32'h0 : v.ir);
    check({v.name, ".MEMOutout"}, MEMOutout, v.exp_mem);
    if (v.kind != K_MIS) check({v.name, ".ALUOutout"}, ALUOutout, v.alu);
    @(posedge clk); #1;
    check({v.name, ".bubble_valid"}, {31'h0, out_valid}, 32'h0);
    check({v.name, ".bubble_IRout"}, IRout, 32'h0);
    check({v.name, ".hold_MEMOutout"}, MEMOutout, v.exp_mem);
    if (v.kind != K_MIS) check({v.name, ".hold_ALUOutout"}, ALUOutout, v.alu);
  endtask

  initial begin
    int stalls;
    rst = 1'b1; in_valid = 1'b0; ALUOutin = 0; Bin = 0; IRin = 0;
    dmem_rdata = 0; dmem_ack = 1'b0;

    //            name        kind      ir            alu       b             rdata        dly addr       wdata        we    be       mem
    vecs.push_back('{"add",   K_NONMEM, 32'h00851020, 32'h10,   32'h0,        32'h0,        0, 32'h0,     32'h0,       1'b0, 4'h0,    32'h0});
    vecs.push_back('{"lw",    K_MEM,    32'h8C430000, 32'h100,  32'h0,        32'hDEADBEEF, 3, 32'h100,   32'h0,       1'b0, 4'hF,    32'hDEADBEEF});
    vecs.push_back('{"sw",    K_MEM,    32'hAC430004, 32'h204,  32'hCAFEF00D, 32'h0,        1, 32'h204,   32'hCAFEF00D,1'b1, 4'hF,    32'h0});
    vecs.push_back('{"lw_mis",K_MIS,    32'h8C430002, 32'h102,  32'h0,        32'h0,        0, 32'h0,     32'h0,       1'b0, 4'h0,    32'h0});
    vecs.push_back('{"sw_mis",K_MIS,    32'hAC430001, 32'h201,  32'h55,       32'h0,        0, 32'h0,     32'h0,       1'b0, 4'h0,    32'h0});
    vecs.push_back('{"lw_ack16",K_MEM,  32'h8C440008, 32'h308,  32'h0,        32'h01234567,16, 32'h308,   32'h0,       1'b0, 4'hF,    32'h01234567});
`ifdef MEM_ACCESS_SUBWORD_EN
    vecs.push_back('{"lb",    K_MEM,    32'h80430103, 32'h103,  32'h0,        32'h80FF0000, 2, 32'h100,   32'h0,       1'b0, 4'hF,    32'hFFFFFF80});
    vecs.push_back('{"lbu",   K_MEM,    32'h90430103, 32'h103,  32'h0,        32'h80FF0000, 1, 32'h100,   32'h0,       1'b0, 4'hF,    32'h00000080});
    vecs.push_back('{"lh",    K_MEM,    32'h84430102, 32'h102,  32'h0,        32'h80FF0000, 1, 32'h100,   32'h0,       1'b0, 4'hF,    32'hFFFF80FF});
    vecs.push_back('{"lhu",   K_MEM,    32'h94430100, 32'h100,  32'h0,        32'h12348765, 2, 32'h100,   32'h0,       1'b0, 4'hF,    32'h00008765});
    vecs.push_back('{"sh",    K_MEM,    32'hA4430042, 32'h42,   32'h1234ABCD, 32'h0,        1, 32'h40,    32'hABCDABCD,1'b1, 4'b1100, 32'h0});
    vecs.push_back('{"sb",    K_MEM,    32'hA0430041, 32'h41,   32'h000000A5, 32'h0,        1, 32'h40,    32'hA5A5A5A5,1'b1, 4'b0010, 32'h0});
    vecs.push_back('{"lh_mis",K_MIS,    32'h84430101, 32'h101,  32'h0,        32'h0,        0, 32'h0,     32'h0,       1'b0, 4'h0,    32'h0});
`else
    vecs.push_back('{"lb_nm", K_NONMEM, 32'h80430103, 32'h103,  32'h0,        32'h0,        0, 32'h0,     32'h0,       1'b0, 4'h0,    32'h0});
    vecs.push_back('{"sh_nm", K_NONMEM, 32'hA4430042, 32'h42,   32'h1234ABCD, 32'h0,        0, 32'h0,     32'h0,       1'b0, 4'h0,    32'h0});
`endif

    #1;
    check("rst.stall", {31'h0, stall}, 32'h0);
    check("rst.req", {31'h0, dmem_req}, 32'h0);
    check("rst.out_valid", {31'h0, out_valid}, 32'h0);
    check("rst.IRout", IRout, 32'h0);
    check("rst.MEMOutout", MEMOutout, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // sw with no ack: expect timeout after 16 request cycles.
    @(negedge clk);
    in_valid = 1'b1; IRin = 32'hAC430010; ALUOutin = 32'h410; Bin = 32'h77;
    @(posedge clk); #1;
    in_valid = 1'b0;
    stalls = 0;
    for (int k = 0; k < 40 && stall; k++) begin
      stalls++;
      @(posedge clk); #1;
    end
    check("to.stall_cycles", stalls, 16);
    check("to.timeout", {31'h0, timeout}, 32'h1);
    check("to.out_valid", {31'h0, out_valid}, 32'h1);
    check("to.req", {31'h0, dmem_req}, 32'h0);
    check("to.IRout", IRout, 32'h0);
    check("to.MEMOutout", MEMOutout, 32'h0);
    @(posedge clk); #1;
    check("to.pulse_end", {30'h0, timeout, out_valid}, 32'h0);

    // Stray ack while idle must be ignored.
    @(negedge clk); dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1; dmem_ack = 1'b0;
    check("stray.out_valid", {31'h0, out_valid}, 32'h0);
    check("stray.stall", {31'h0, stall}, 32'h0);

    // Reset during a request abandons it.
    @(negedge clk);
    in_valid = 1'b1; IRin = 32'h8C430020; ALUOutin = 32'h520;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rr.req_before", {31'h0, dmem_req}, 32'h1);
    @(posedge clk);
    @(negedge clk); rst = 1'b1; #1;
    check("rr.req_async", {31'h0, dmem_req}, 32'h0);
    check("rr.stall_async", {31'h0, stall}, 32'h0);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("rr.no_valid", {31'h0, out_valid}, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
